// File: rtl/step_pulse_gen.sv
// step_pulse_gen: step/dir/enable generator for a stepper driver, with a linear period ramp.
// Define STEP_LIMIT_EN to add step_limit/limit_hit, which stop the run after a set number of steps.
module step_pulse_gen #(
    parameter int PERIOD_MAX = 50000,
    parameter int PERIOD_MIN = 5000,
    parameter int ACC_STEP   = 500,
    parameter int PULSE_W    = 100,
    parameter int DIR_SETUP  = 50
) (
    input  logic        sclk,
    input  logic        s_rst_n,
    input  logic        direct,
    input  logic        enable,
`ifdef STEP_LIMIT_EN
    input  logic [15:0] step_limit,
    output logic        limit_hit,
`endif
    output logic        step,
    output logic        dir,
    output logic        drv_en,
    output logic        busy,
    output logic [15:0] step_cnt
);
    typedef enum logic [1:0] {IDLE, SETUP, RUN, DECEL} state_t;
    localparam logic [15:0] P_MAX = 16'(PERIOD_MAX);
    localparam logic [15:0] P_MIN = 16'(PERIOD_MIN);
    localparam logic [15:0] P_ACC = 16'(ACC_STEP);
    localparam logic [15:0] P_W   = 16'(PULSE_W);
    localparam logic [15:0] P_DS  = 16'(DIR_SETUP);

    state_t      state, state_n;
    logic [15:0] timer, timer_n, period, period_n, setup_cnt, setup_cnt_n, step_cnt_n;
    logic [15:0] period_dn, period_up;
    logic [16:0] period_sum;
    logic        dir_n, step_n, bound, run_req, lim;

    assign bound      = timer == period - 16'd1;
    assign period_sum = {1'b0, period} + {1'b0, P_ACC};
    assign period_up  = (period_sum >= {1'b0, P_MAX}) ? P_MAX : period_sum[15:0];
    assign period_dn  = ({1'b0, period} >= {1'b0, P_MIN} + {1'b0, P_ACC}) ? period - P_ACC : P_MIN;
    assign busy       = state != IDLE;

`ifdef STEP_LIMIT_EN
    logic limit_hit_n;
    assign lim     = (step_limit != 16'd0) && (step_cnt + 16'd1 >= step_limit);
    // once the limit has fired, the run winds down exactly as if enable had dropped
    assign run_req = enable & ~limit_hit;
`else
    assign lim     = 1'b0;
    assign run_req = enable;
`endif

    always_comb begin
        state_n     = state;
        timer_n     = timer;
        period_n    = period;
        setup_cnt_n = setup_cnt;
        step_cnt_n  = step_cnt;
        dir_n       = dir;
`ifdef STEP_LIMIT_EN
        limit_hit_n = limit_hit;
`endif
        case (state)
            IDLE: if (enable) begin
                state_n     = SETUP;
                dir_n       = direct;
                timer_n     = '0;
                period_n    = P_MAX;
                setup_cnt_n = '0;
                step_cnt_n  = '0;
`ifdef STEP_LIMIT_EN
                limit_hit_n = 1'b0;
`endif
            end
            SETUP: begin
                if (!enable) state_n = IDLE;
                else if (setup_cnt == P_DS) begin
                    state_n = RUN;
                    timer_n = '0;
                end else setup_cnt_n = setup_cnt + 16'd1;
            end
            default: begin
                timer_n = bound ? '0 : timer + 16'd1;
                if (bound) begin
                    step_cnt_n = step_cnt + 16'd1;
                    if (state == RUN) begin
                        if (!run_req || direct != dir || lim) state_n = DECEL;
                        else period_n = period_dn;
`ifdef STEP_LIMIT_EN
                        limit_hit_n = limit_hit | lim;
`endif
                    end else if (period == P_MAX) begin
                        state_n     = !run_req ? IDLE : (direct != dir) ? SETUP : RUN;
                        dir_n       = run_req ? direct : dir;
                        setup_cnt_n = '0;
                    end else if (run_req && direct == dir) state_n = RUN;
                    else period_n = period_up;
                end
            end
        endcase
        step_n = (state_n == RUN || state_n == DECEL) && timer_n < P_W;
    end

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state     <= IDLE;
            timer     <= '0;
            period    <= P_MAX;
            setup_cnt <= '0;
            step_cnt  <= '0;
            dir       <= 1'b0;
            step      <= 1'b0;
            drv_en    <= 1'b0;
`ifdef STEP_LIMIT_EN
            limit_hit <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            timer     <= timer_n;
            period    <= period_n;
            setup_cnt <= setup_cnt_n;
            step_cnt  <= step_cnt_n;
            dir       <= dir_n;
            step      <= step_n;
            drv_en    <= state_n != IDLE;
`ifdef STEP_LIMIT_EN
            limit_hit <= limit_hit_n;
`endif
        end
    end
endmodule

// File: tb/tb_step_pulse_gen.sv
// tb_step_pulse_gen: scoreboard bench for step_pulse_gen; expected step rise cycles are queued by each scenario.
module tb_step_pulse_gen;
    localparam int PMAX = 20, PMIN = 8, ACC = 4, PW = 3, DS = 5;

    logic        sclk = 0, s_rst_n = 1, direct = 0, enable = 0;
    logic        step, dir, drv_en, busy;
    logic [15:0] step_cnt;
`ifdef STEP_LIMIT_EN
    logic [15:0] step_limit = 0;
    logic        limit_hit;
`endif

    int checks = 0, failures = 0, cyc = 0;
    int exp_q[$];
    int m_last, m_p, m_n;
    bit mon_en = 0;

    step_pulse_gen #(.PERIOD_MAX(PMAX), .PERIOD_MIN(PMIN), .ACC_STEP(ACC), .PULSE_W(PW), .DIR_SETUP(DS)) dut (
        .sclk(sclk),
        .s_rst_n(s_rst_n),
        .direct(direct),
        .enable(enable),
`ifdef STEP_LIMIT_EN
        .step_limit(step_limit),
        .limit_hit(limit_hit),
`endif
        .step(step),
        .dir(dir),
        .drv_en(drv_en),
        .busy(busy),
        .step_cnt(step_cnt)
    );

    always #5 sclk = ~sclk;
    always @(posedge sclk) cyc <= cyc + 1;

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge sclk);
            #1;
        end
    endtask

    task automatic push_rise(int r);
        exp_q.push_back(r);
        m_last = r;
        m_n++;
    endtask

    task automatic ramp(int k);
        int r;
        repeat (k) begin
            r   = m_last + m_p;
            m_p = (m_p - ACC > PMIN) ? m_p - ACC : PMIN;
            push_rise(r);
        end
    endtask

    // next boundary enters DECEL holding the period, then each boundary slows until PMAX
    task automatic push_stop(output int end_cyc);
        int r;
        r = m_last + m_p;
        push_rise(r);
        while (m_p < PMAX) begin
            r   = m_last + m_p;
            m_p = (m_p + ACC < PMAX) ? m_p + ACC : PMAX;
            push_rise(r);
        end
        end_cyc = m_last + m_p;
    endtask

    task automatic start_run(bit d, output int n);
        direct = d;
        enable = 1;
        tick();
        n   = cyc;
        m_n = 0;
        m_p = PMAX;
        push_rise(n + DS + 1);
    endtask

    task automatic drain(output bit ok);
        for (int i = 0; i < 600 && exp_q.size() != 0; i++) tick();
        ok = exp_q.size() == 0;
    endtask

    task automatic monitor();
        logic ps = 0, pd = 0;
        int   hs = 0, e;
        forever begin
            @(negedge sclk);
            if (mon_en) begin
                if (step === 1'b1 && ps === 1'b0) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL step_rise got unexpected pulse at cyc=%0d required none", cyc);
                    end else begin
                        e = exp_q.pop_front();
                        if (cyc != e) begin
                            failures++;
                            $display("FAIL step_rise got cyc=%0d required cyc=%0d", cyc, e);
                        end
                    end
                    hs = cyc;
                end
                if (step === 1'b0 && ps === 1'b1) begin
                    checks++;
                    if (cyc - hs != PW) begin
                        failures++;
                        $display("FAIL step_width got %0d required %0d", cyc - hs, PW);
                    end
                end
                if (dir !== pd) begin
                    checks++;
                    if (step === 1'b1 || ps === 1'b1) begin
                        failures++;
                        $display("FAIL dir_stable got dir edge with step high at cyc=%0d required step low", cyc);
                    end
                end
            end
            ps = step;
            pd = dir;
        end
    endtask

    task automatic test_reset();
        #3 s_rst_n = 0;
        #1;
        checks++;
        if ({step, dir, drv_en, busy} !== 4'b0) begin
            failures++;
            $display("FAIL reset_flags got %b required 0000", {step, dir, drv_en, busy});
        end
        checks++;
        if (step_cnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_cnt got %0d required 0", step_cnt);
        end
        tick(2);
        s_rst_n = 1;
        tick(3);
        checks++;
        if (busy !== 1'b0 || drv_en !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle got busy=%b drv_en=%b required 0 0", busy, drv_en);
        end
    endtask

    task automatic test_start();
        int n;
        bit ok;
        mon_en = 1;
        start_run(1, n);
        checks++;
        if (dir !== 1'b1 || drv_en !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL start_outputs got dir=%b drv_en=%b busy=%b required 1 1 1", dir, drv_en, busy);
        end
        checks++;
        if (step !== 1'b0 || step_cnt !== 16'd0) begin
            failures++;
            $display("FAIL start_step got step=%b cnt=%0d required 0 0", step, step_cnt);
        end
        ramp(5);
        drain(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL start_drain got %0d pending rises required 0", exp_q.size());
        end
        checks++;
        if (step_cnt !== 16'(m_n - 1)) begin
            failures++;
            $display("FAIL start_cnt got %0d required %0d", step_cnt, m_n - 1);
        end
    endtask

    task automatic test_stop();
        int e;
        bit ok;
        enable = 0;
        push_stop(e);
        drain(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL stop_drain got %0d pending rises required 0", exp_q.size());
        end
        while (cyc < e - 1) tick();
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL stop_last_period got busy=%b required 1", busy);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || drv_en !== 1'b0) begin
            failures++;
            $display("FAIL stop_idle got busy=%b drv_en=%b required 0 0", busy, drv_en);
        end
        tick(10);
        checks++;
        if (step_cnt !== 16'(m_n)) begin
            failures++;
            $display("FAIL stop_cnt got %0d required %0d", step_cnt, m_n);
        end
    endtask

    task automatic test_reversal();
        int n, e;
        bit ok;
        start_run(1, n);
        ramp(5);
        drain(ok);
        direct = 0;
        push_stop(e);
        drain(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL rev_decel got %0d pending rises required 0", exp_q.size());
        end
        while (cyc < e - 1) tick();
        checks++;
        if (dir !== 1'b1) begin
            failures++;
            $display("FAIL rev_dir_before got %b required 1", dir);
        end
        tick();
        checks++;
        if (dir !== 1'b0 || busy !== 1'b1 || step !== 1'b0) begin
            failures++;
            $display("FAIL rev_setup got dir=%b busy=%b step=%b required 0 1 0", dir, busy, step);
        end
        checks++;
        if (step_cnt !== 16'(m_n)) begin
            failures++;
            $display("FAIL rev_cnt got %0d required %0d", step_cnt, m_n);
        end
        m_p = PMAX;
        push_rise(e + DS + 1);
        ramp(4);
        drain(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL rev_reaccel got %0d pending rises required 0", exp_q.size());
        end
        enable = 0;
        push_stop(e);
        drain(ok);
        while (cyc < e) tick();
        checks++;
        if (busy !== 1'b0 || step_cnt !== 16'(m_n)) begin
            failures++;
            $display("FAIL rev_stop got busy=%b cnt=%0d required 0 %0d", busy, step_cnt, m_n);
        end
    endtask

    task automatic test_abort();
        direct = 1;
        enable = 1;
        tick();
        checks++;
        if (busy !== 1'b1 || drv_en !== 1'b1 || step_cnt !== 16'd0) begin
            failures++;
            $display("FAIL abort_setup got busy=%b drv_en=%b cnt=%0d required 1 1 0", busy, drv_en, step_cnt);
        end
        tick(2);
        enable = 0;
        tick();
        checks++;
        if (busy !== 1'b0 || drv_en !== 1'b0) begin
            failures++;
            $display("FAIL abort_idle got busy=%b drv_en=%b required 0 0", busy, drv_en);
        end
        tick(DS + 5);
        checks++;
        if (step !== 1'b0 || step_cnt !== 16'd0) begin
            failures++;
            $display("FAIL abort_nostep got step=%b cnt=%0d required 0 0", step, step_cnt);
        end
    endtask

    task automatic test_reset_midrun();
        int n;
        start_run(1, n);
        ramp(7);
        for (int i = 0; i < 400 && !(step === 1'b1 && step_cnt === 16'd7); i++) tick();
        checks++;
        if (step !== 1'b1 || step_cnt !== 16'd7) begin
            failures++;
            $display("FAIL midrun_reach got step=%b cnt=%0d required 1 7", step, step_cnt);
        end
        mon_en = 0;
        #2 s_rst_n = 0;
        #1;
        checks++;
        if ({step, dir, drv_en, busy} !== 4'b0 || step_cnt !== 16'd0) begin
            failures++;
            $display("FAIL midrun_reset got flags=%b cnt=%0d required 0000 0", {step, dir, drv_en, busy}, step_cnt);
        end
        exp_q.delete();
        enable = 0;
        tick(2);
        s_rst_n = 1;
        tick(5);
        checks++;
        if (busy !== 1'b0 || drv_en !== 1'b0 || step !== 1'b0) begin
            failures++;
            $display("FAIL midrun_idle got busy=%b drv_en=%b step=%b required 0 0 0", busy, drv_en, step);
        end
        mon_en = 1;
    endtask

`ifdef STEP_LIMIT_EN
    task automatic test_limit();
        int n, e, r_hit;
        bit ok;
        step_limit = 16'd5;
        start_run(1, n);
        ramp(4);
        r_hit = m_last + m_p;
        push_stop(e);
        for (int i = 0; i < 400 && limit_hit !== 1'b1; i++) tick();
        checks++;
        if (limit_hit !== 1'b1 || cyc != r_hit || step_cnt !== 16'd5) begin
            failures++;
            $display("FAIL limit_hit got hit=%b cyc=%0d cnt=%0d required 1 %0d 5", limit_hit, cyc, step_cnt, r_hit);
        end
        enable = 0;
        drain(ok);
        while (cyc < e) tick();
        checks++;
        if (busy !== 1'b0 || step_cnt !== 16'(m_n) || limit_hit !== 1'b1) begin
            failures++;
            $display("FAIL limit_stop got busy=%b cnt=%0d hit=%b required 0 %0d 1", busy, step_cnt, limit_hit, m_n);
        end
        step_limit = 16'd0;
        enable = 1;
        tick();
        checks++;
        if (limit_hit !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL limit_clear got hit=%b busy=%b required 0 1", limit_hit, busy);
        end
        enable = 0;
        tick(2);
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout required finish");
        $fatal(1);
    end

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_start();
        test_stop();
        test_reversal();
        test_abort();
        test_reset_midrun();
`ifdef STEP_LIMIT_EN
        test_limit();
`endif
        tick(3);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL final_queue got %0d pending rises required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
